// File: rtl/pivot_cyc_store_if.sv
// Memory-side bus of pivot_cyc_store: one simple dual-port RAM port pair.
//
// Signals:
//   mem_data  write word, lane gi slice at [gi*B +: B] (parity bits above N*B when enabled)
//   mem_q     read word, same layout as mem_data
//   mem_addr  word address for both read and write
//   mem_rden  read enable
//   mem_wren  write enable
//
// Handshake: there is no back-pressure. A cycle with mem_wren=1 is a complete
// write of mem_data to mem_addr. A cycle with mem_rden=1 is a read request for
// mem_addr whose data the slave presents on mem_q exactly READ_LAT cycles later.
// mem_rden and mem_wren are never high in the same cycle.
//
// Modports: master = pivot_cyc_store, slave = the RAM.
interface pivot_cyc_store_if #(
  parameter int MW = 8,
  parameter int AW = 4
);
  logic [MW-1:0] mem_data;
  logic [MW-1:0] mem_q;
  logic [AW-1:0] mem_addr;
  logic          mem_rden;
  logic          mem_wren;

  modport master (
    output mem_data,
    output mem_addr,
    output mem_rden,
    output mem_wren,
    input  mem_q
  );

  modport slave (
    input  mem_data,
    input  mem_addr,
    input  mem_rden,
    input  mem_wren,
    output mem_q
  );
endinterface

// File: rtl/pivot_cyc_store.sv
// pivot_cyc_store: per-lane pivot cycle counter storage with multi-bit
// save/restore to an external RAM region selected by phase_id.
//
// Holds N lane registers of LW = $clog2(L) bits. A save (pivot=1, done_in)
// writes BEATS = ceil(LW/B) words carrying B bits of every lane; a restore
// (pivot=0, start_in) reads them back, tolerating READ_LAT cycles of read
// latency. abort cancels any transfer and discards reads still in flight.
//
// Optional feature macro: PIVOT_CYC_PARITY_EN
//   defined   : each lane slice carries an even-parity bit at mem word bit
//               N*B+gi; sticky parity_err flags a bad captured beat and clears
//               on the next restore entry or reset.
//   undefined : no parity bits, no parity_err port.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start_in/out      start pulse from upstream / to downstream
//   done_in/out       done pulse from upstream / to downstream
//   pivot             1 = pivot pass (save), 0 = replay pass (restore)
//   abort             early-abort pulse, cancels any transfer
//   pivot_cmd         per-lane load strobe for op_cyc_ctr (IDLE only)
//   op_cyc_ctr        value loaded on pivot_cmd
//   phase_id          memory region select
//   pivot_cyc_packed  lane gi at [gi*LW +: LW]
//   busy              transfer in progress
//   dbg_state         current FSM state (IDLE=0, WRITE=1, READ=2, DRAIN=3)
//   parity_err        sticky parity error (PIVOT_CYC_PARITY_EN only)
//   mem               RAM bus (pivot_cyc_store_if.master)
module pivot_cyc_store #(
  parameter int N        = 64,
  parameter int L        = 768,
  parameter int B        = 2,
  parameter int READ_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_in,
  output logic                          start_out,
  input  logic                          done_in,
  output logic                          done_out,
  input  logic                          pivot,
  input  logic                          abort,
  input  logic [N-1:0]                  pivot_cmd,
  input  logic [$clog2(L)-1:0]          op_cyc_ctr,
  input  logic [$clog2(L/N+1)-1:0]      phase_id,
  output logic [$clog2(L)*N-1:0]        pivot_cyc_packed,
  output logic                          busy,
  output logic [1:0]                    dbg_state,
`ifdef PIVOT_CYC_PARITY_EN
  output logic                          parity_err,
`endif
  pivot_cyc_store_if.master             mem
);

  localparam int LW    = $clog2(L);
  localparam int BEATS = (LW + B - 1) / B;
  localparam int AW    = $clog2(BEATS * (L / N + 1));
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef PIVOT_CYC_PARITY_EN
  localparam int MW    = N * (B + 1);
`else
  localparam int MW    = N * B;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [KW-1:0]                 beat_q, beat_d;
  logic [AW-1:0]                 base_q, base_d;
  logic [N-1:0][LW-1:0]          lane_q;

  // Read tag pipeline: one stage per cycle of read latency. Stage READ_LAT-1
  // lines up with the cycle mem_q carries the data for its beat index.
  logic [READ_LAT-1:0]           tag_v_q;
  logic [READ_LAT-1:0][KW-1:0]   tag_k_q;

  logic                          start_out_q, done_out_q;
  logic                          wren_c, rden_c;
  logic                          write_done, read_done;
  logic                          trig_write, trig_read;
  logic                          last_beat;
  logic                          cap_v, cap_last;
  logic [KW-1:0]                 cap_k;
  logic [AW-1:0]                 base_new;
  logic [MW-1:0]                 wdata;

  assign base_new   = AW'(phase_id) * AW'(BEATS);
  assign last_beat  = (beat_q == KW'(BEATS - 1));
  assign trig_write = (state_q == IDLE) && pivot && done_in && !abort;
  assign trig_read  = (state_q == IDLE) && !pivot && start_in && !abort;

  // A capture in the abort cycle is dropped along with the rest of the pipe.
  assign cap_k    = tag_k_q[READ_LAT-1];
  assign cap_v    = tag_v_q[READ_LAT-1] && !abort;
  assign cap_last = cap_v && (cap_k == KW'(BEATS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    wren_c     = 1'b0;
    rden_c     = 1'b0;
    write_done = 1'b0;
    read_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_write) begin
          state_d = WRITE;
          beat_d  = '0;
          base_d  = base_new;
        end else if (trig_read) begin
          state_d = READ;
          beat_d  = '0;
          base_d  = base_new;
        end
      end
      WRITE: begin
        wren_c = 1'b1;
        if (last_beat) begin
          state_d    = IDLE;
          beat_d     = '0;
          write_done = !abort;
        end else begin
          beat_d = beat_q + KW'(1);
        end
      end
      READ: begin
        rden_c = 1'b1;
        if (last_beat) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + KW'(1);
        end
      end
      DRAIN: begin
        // Reads keep landing in DRAIN; the last slice closes the restore.
        if (cap_last) begin
          state_d   = IDLE;
          read_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      beat_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Write data: beat k carries bits [k*B +: B] of every lane; bits past LW in
  // the final beat stay zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    wdata = '0;
    if (state_q == WRITE) begin
      for (int gi = 0; gi < N; gi++) begin
        for (int b = 0; b < LW; b++) begin
          if (beat_q == KW'(b / B)) begin
            wdata[gi*B + b%B] = lane_q[gi][b];
          end
        end
      end
`ifdef PIVOT_CYC_PARITY_EN
      for (int gi = 0; gi < N; gi++) begin
        wdata[N*B + gi] = ^wdata[gi*B +: B];
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      tag_k_q <= '0;
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1] && !abort;
        tag_k_q[i] <= tag_k_q[i-1];
      end
      tag_v_q[0] <= rden_c && !abort;
      tag_k_q[0] <= beat_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane registers. Restore data wins over pivot_cmd; pivot_cmd only acts in
  // IDLE. Padding bits of the final read beat are never written anywhere.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else begin
      for (int gi = 0; gi < N; gi++) begin
        if (cap_v) begin
          for (int b = 0; b < LW; b++) begin
            if (cap_k == KW'(b / B)) begin
              lane_q[gi][b] <= mem.mem_q[gi*B + b%B];
            end
          end
        end else if ((state_q == IDLE) && pivot_cmd[gi]) begin
          lane_q[gi] <= op_cyc_ctr;
        end
      end
    end
  end

`ifdef PIVOT_CYC_PARITY_EN
  logic par_bad;

  always_comb begin
    par_bad = 1'b0;
    if (cap_v) begin
      for (int gi = 0; gi < N; gi++) begin
        if ((^mem.mem_q[gi*B +: B]) != mem.mem_q[N*B + gi]) begin
          par_bad = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (trig_read) begin
      parity_err <= 1'b0;
    end else if (par_bad) begin
      parity_err <= 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Pulses: completion pulses plus the registered pass-through of whichever
  // upstream pulse is not used as the trigger in this mode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_out_q <= 1'b0;
      done_out_q  <= 1'b0;
    end else begin
      start_out_q <= read_done  || (pivot  && start_in && !abort);
      done_out_q  <= write_done || (!pivot && done_in  && !abort);
    end
  end

  assign start_out        = start_out_q;
  assign done_out         = done_out_q;
  assign busy             = (state_q != IDLE);
  assign dbg_state        = state_q;
  assign pivot_cyc_packed = lane_q;

  assign mem.mem_data = wdata;
  assign mem.mem_addr = base_q + AW'(beat_q);
  assign mem.mem_wren = wren_c;
  assign mem.mem_rden = rden_c;

endmodule

// File: tb/tb_pivot_cyc_store.sv
// Testbench for pivot_cyc_store. Two instances share one stimulus stream:
// B=2 (even split) and B=3 (padded final beat), both N=4, L=16, READ_LAT=3.
// Each has its own RAM model. Expected bus beats and output pulses are queued
// when stimulus is issued; negedge monitors pop and compare.
module tb_pivot_cyc_store;
  localparam int N     = 4;
  localparam int L     = 16;
  localparam int RL    = 3;
  localparam int LW    = 4;
  localparam int BEATS = 2;
  localparam int PH    = L / N + 1;
  localparam int AW    = 4;
  localparam int PW    = 3;
`ifdef PIVOT_CYC_PARITY_EN
  localparam int MW2 = N * 3;
  localparam int MW3 = N * 4;
`else
  localparam int MW2 = N * 2;
  localparam int MW3 = N * 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic            start_in, done_in, pivot, abort;
  logic [N-1:0]    pivot_cmd;
  logic [LW-1:0]   op_cyc_ctr;
  logic [PW-1:0]   phase_id;
  logic            start_out2, done_out2, busy2, start_out3, done_out3, busy3;
  logic [N*LW-1:0] packed2, packed3;
  logic [1:0]      dbg2, dbg3;
`ifdef PIVOT_CYC_PARITY_EN
  logic            perr2, perr3;
`endif

  pivot_cyc_store_if #(.MW(MW2), .AW(AW)) m2 ();
  pivot_cyc_store_if #(.MW(MW3), .AW(AW)) m3 ();

  pivot_cyc_store #(.N(N), .L(L), .B(2), .READ_LAT(RL)) u2 (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .start_out(start_out2),
    .done_in(done_in), .done_out(done_out2), .pivot(pivot), .abort(abort),
    .pivot_cmd(pivot_cmd), .op_cyc_ctr(op_cyc_ctr), .phase_id(phase_id),
    .pivot_cyc_packed(packed2), .busy(busy2), .dbg_state(dbg2),
`ifdef PIVOT_CYC_PARITY_EN
    .parity_err(perr2),
`endif
    .mem(m2.master)
  );

  pivot_cyc_store #(.N(N), .L(L), .B(3), .READ_LAT(RL)) u3 (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .start_out(start_out3),
    .done_in(done_in), .done_out(done_out3), .pivot(pivot), .abort(abort),
    .pivot_cmd(pivot_cmd), .op_cyc_ctr(op_cyc_ctr), .phase_id(phase_id),
    .pivot_cyc_packed(packed3), .busy(busy3), .dbg_state(dbg3),
`ifdef PIVOT_CYC_PARITY_EN
    .parity_err(perr3),
`endif
    .mem(m3.master)
  );

  // ---------------- RAM models (READ_LAT pipeline, junk when idle) ----------------
  logic [MW2-1:0] mem2 [PH*BEATS];
  logic [MW2-1:0] pipe2 [RL];
  logic [MW3-1:0] mem3 [PH*BEATS];
  logic [MW3-1:0] pipe3 [RL];

  always @(posedge clk) begin
    if (m2.mem_wren) mem2[m2.mem_addr] <= m2.mem_data;
    for (int i = RL - 1; i > 0; i--) pipe2[i] <= pipe2[i-1];
    pipe2[0] <= m2.mem_rden ? mem2[m2.mem_addr] : MW2'($urandom);
  end
  always @(posedge clk) begin
    if (m3.mem_wren) mem3[m3.mem_addr] <= m3.mem_data;
    for (int i = RL - 1; i > 0; i--) pipe3[i] <= pipe3[i-1];
    pipe3[0] <= m3.mem_rden ? mem3[m3.mem_addr] : MW3'($urandom);
  end
  assign m2.mem_q = pipe2[RL-1];
  assign m3.mem_q = pipe3[RL-1];

  // ---------------- reference model ----------------
  int model_lane [N];
  int tgt [N];
  int saved [PH][N];
  bit saved_ok [PH];

  // Word written on beat k for lane width bw: bits [k*bw +: bw] of each lane.
  function automatic logic [31:0] beat_word(int bw, int k);
    logic [31:0] w;
    int s;
    w = '0;
    for (int gi = 0; gi < N; gi++) begin
      s = (model_lane[gi] >> (k * bw)) & ((1 << bw) - 1);
      w = w | (32'(s) << (gi * bw));
`ifdef PIVOT_CYC_PARITY_EN
      w[N*bw + gi] = ($countones(s) % 2) != 0;
`endif
    end
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  logic [21:0] exp_bus2_q[$];   // {kind: 01 write / 10 read, addr, data}
  logic [21:0] exp_bus3_q[$];
  logic [39:0] exp_pul2_q[$];   // {kind: 1 start_out / 2 done_out, cycle}
  logic [39:0] exp_pul3_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_pulse(int kind, int c);
    exp_pul2_q.push_back({8'(kind), 32'(c)});
    exp_pul3_q.push_back({8'(kind), 32'(c)});
  endtask

  always @(negedge clk) begin
    logic [21:0] got;
    if (rst_n && (m2.mem_wren || m2.mem_rden)) begin
      got = {m2.mem_rden, m2.mem_wren, m2.mem_addr, 16'(m2.mem_data & {MW2{m2.mem_wren}})};
      check("b2 bus beat expected", 64'(exp_bus2_q.size() != 0), 64'd1);
      if (exp_bus2_q.size() != 0) check("b2 bus beat", 64'(got), 64'(exp_bus2_q.pop_front()));
    end
    if (rst_n && (m3.mem_wren || m3.mem_rden)) begin
      got = {m3.mem_rden, m3.mem_wren, m3.mem_addr, 16'(m3.mem_data & {MW3{m3.mem_wren}})};
      check("b3 bus beat expected", 64'(exp_bus3_q.size() != 0), 64'd1);
      if (exp_bus3_q.size() != 0) check("b3 bus beat", 64'(got), 64'(exp_bus3_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && start_out2) begin
      check("b2 start_out expected", 64'(exp_pul2_q.size() != 0), 64'd1);
      if (exp_pul2_q.size() != 0) check("b2 start_out", {8'd1, 32'(cyc)}, 64'(exp_pul2_q.pop_front()));
    end
    if (rst_n && done_out2) begin
      check("b2 done_out expected", 64'(exp_pul2_q.size() != 0), 64'd1);
      if (exp_pul2_q.size() != 0) check("b2 done_out", {8'd2, 32'(cyc)}, 64'(exp_pul2_q.pop_front()));
    end
    if (rst_n && start_out3) begin
      check("b3 start_out expected", 64'(exp_pul3_q.size() != 0), 64'd1);
      if (exp_pul3_q.size() != 0) check("b3 start_out", {8'd1, 32'(cyc)}, 64'(exp_pul3_q.pop_front()));
    end
    if (rst_n && done_out3) begin
      check("b3 done_out expected", 64'(exp_pul3_q.size() != 0), 64'd1);
      if (exp_pul3_q.size() != 0) check("b3 done_out", {8'd2, 32'(cyc)}, 64'(exp_pul3_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(string name);
    logic [N*LW-1:0] e;
    e = '0;
    for (int gi = 0; gi < N; gi++) e[gi*LW +: LW] = LW'(model_lane[gi]);
    check({name, " b2 lanes"}, 64'(packed2), 64'(e));
    check({name, " b3 lanes"}, 64'(packed3), 64'(e));
  endtask

  task automatic load_lanes();
    for (int gi = 0; gi < N; gi++) begin
      pivot_cmd  = N'(1) << gi;
      op_cyc_ctr = LW'(tgt[gi]);
      model_lane[gi] = tgt[gi];
      tick();
    end
    pivot_cmd = '0;
  endtask

  task automatic rand_tgt();
    for (int gi = 0; gi < N; gi++) tgt[gi] = $urandom_range(0, 15);
  endtask

  // poke: during the first WRITE beat, also strobe every lane and re-issue
  // done_in; both must be ignored.
  task automatic save(int ph, bit poke);
    int c0;
    pivot = 1'b1; done_in = 1'b1; phase_id = PW'(ph); c0 = cyc;
    for (int k = 0; k < BEATS; k++) begin
      exp_bus2_q.push_back({2'b01, AW'(ph * BEATS + k), 16'(beat_word(2, k))});
      exp_bus3_q.push_back({2'b01, AW'(ph * BEATS + k), 16'(beat_word(3, k))});
    end
    push_pulse(2, c0 + BEATS + 1);
    saved[ph] = model_lane;
    saved_ok[ph] = 1'b1;
    tick();
    done_in = poke; pivot_cmd = poke ? '1 : '0; op_cyc_ctr = 4'd7;
    tick();
    done_in = 1'b0; pivot_cmd = '0;
    repeat (BEATS + 1) tick();
  endtask

  task automatic push_reads(int ph);
    for (int k = 0; k < BEATS; k++) begin
      exp_bus2_q.push_back({2'b10, AW'(ph * BEATS + k), 16'h0});
      exp_bus3_q.push_back({2'b10, AW'(ph * BEATS + k), 16'h0});
    end
  endtask

  task automatic restore(int ph);
    int c0;
    pivot = 1'b0; start_in = 1'b1; phase_id = PW'(ph); c0 = cyc;
    push_reads(ph);
    push_pulse(1, c0 + BEATS + RL + 1);
    model_lane = saved[ph];
    tick();
    start_in = 1'b0;
    repeat (BEATS + RL + 2) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    start_in = 0; done_in = 0; pivot = 0; abort = 0;
    pivot_cmd = '0; op_cyc_ctr = '0; phase_id = '0;
    for (int i = 0; i < N; i++) model_lane[i] = 0;
    for (int p = 0; p < PH; p++) saved_ok[p] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset b2 outputs", {busy2, start_out2, done_out2, m2.mem_wren, m2.mem_rden, packed2}, 64'd0);
    check("reset b3 outputs", {busy3, start_out3, done_out3, m3.mem_wren, m3.mem_rden, packed3}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Save / clear / restore at phase 0.
    tgt = '{3, 9, 12, 5};
    load_lanes();
    check_lanes("load");
    save(0, 1'b0);
    check_lanes("after save0");
    tgt = '{0, 0, 0, 0};
    load_lanes();
    check_lanes("cleared");
    restore(0);
    check_lanes("restore0");

    // Max value through the padded beat, phase offset, ignore rules.
    tgt = '{15, 15, 0, 8};
    load_lanes();
    save(2, 1'b1);
    check_lanes("pokes ignored");
    tgt = '{1, 2, 3, 4};
    load_lanes();
    restore(2);
    check_lanes("restore2");
    restore(0);
    check_lanes("phase0 intact");

    // Pass-through pulses.
    pivot = 1'b1; start_in = 1'b1; push_pulse(1, cyc + 1);
    tick();
    start_in = 1'b0; pivot = 1'b0; done_in = 1'b1; push_pulse(2, cyc + 1);
    tick();
    done_in = 1'b0;
    repeat (2) tick();

    // Abort on the second read beat, with a coincident pass-through done_in.
    rand_tgt();
    load_lanes();
    save(1, 1'b0);
    for (int gi = 0; gi < N; gi++) tgt[gi] = model_lane[gi] ^ 10;
    load_lanes();
    pivot = 1'b0; start_in = 1'b1; phase_id = PW'(1);
    push_reads(1);
    tick();
    start_in = 1'b0;
    tick();
    abort = 1'b1; done_in = 1'b1;
    tick();
    abort = 1'b0; done_in = 1'b0;
    check("abort busy", {busy2, busy3}, 64'd0);
    repeat (RL + 3) tick();
    check_lanes("abort lanes kept");
    restore(1);
    check_lanes("restore after abort");

    // Abort and trigger together: nothing starts.
    pivot = 1'b1; done_in = 1'b1; abort = 1'b1; phase_id = '0;
    tick();
    done_in = 1'b0; abort = 1'b0;
    check("abort+trigger busy", {busy2, busy3}, 64'd0);
    repeat (4) tick();

    // Randomized save/restore round trips.
    for (int it = 0; it < 10; it++) begin
      int ph, ph2;
      rand_tgt();
      load_lanes();
      ph = $urandom_range(0, PH - 1);
      save(ph, 1'($urandom_range(0, 1)));
      rand_tgt();
      load_lanes();
      ph2 = $urandom_range(0, PH - 1);
      if (!saved_ok[ph2]) ph2 = ph;
      restore(ph2);
      check_lanes("random restore");
    end

    // Asynchronous reset in the middle of a save.
    pivot = 1'b1; done_in = 1'b1; phase_id = PW'(3);
    tick();
    done_in = 1'b0;
    check("write in progress", {busy2, busy3, m2.mem_wren, m3.mem_wren}, 64'hf);
    #1;
    rst_n = 1'b0;
    #1;
    for (int gi = 0; gi < N; gi++) model_lane[gi] = 0;
    check("midreset b2 outputs", {busy2, start_out2, done_out2, m2.mem_wren, m2.mem_rden}, 64'd0);
    check("midreset b3 outputs", {busy3, start_out3, done_out3, m3.mem_wren, m3.mem_rden}, 64'd0);
    check_lanes("midreset");
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    restore(0);
    check_lanes("restore after reset");

    repeat (4) tick();
    check("b2 bus queue drained", 64'(exp_bus2_q.size()), 64'd0);
    check("b3 bus queue drained", 64'(exp_bus3_q.size()), 64'd0);
    check("b2 pulse queue drained", 64'(exp_pul2_q.size()), 64'd0);
    check("b3 pulse queue drained", 64'(exp_pul3_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pivot_cyc_store.md
Name: pivot_cyc_store

Overview:
Successor storage block for per-lane pivot cycle counters in the single-pass early-abort systemizer. Holds N lane registers of width LW = $clog2(L) and saves/restores them to external memory at a selectable width of B bits per lane per beat, instead of one bit per beat. Supports a configurable memory read latency and an abort input for early-abort/redo. Sits between the pivot control path and a simple dual-port RAM, one memory region per phase.

Parameters:
N, 64, lane count; memory word carries B bits per lane.
L, 768, column count; LW = $clog2(L) bits per counter.
B, 2, bits per lane per beat, 1 <= B <= LW; BEATS = ceil(LW/B).
READ_LAT, 3, cycles from mem_rden to valid mem_q, >= 1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_in  in  1  start pulse from the upstream stage
start_out  out  1  start pulse to the downstream stage
done_in  in  1  done pulse from the upstream stage
done_out  out  1  done pulse to the downstream stage
pivot  in  1  mode: 1 = pivot pass (save), 0 = replay pass (restore)
abort  in  1  early-abort pulse; cancels any transfer
pivot_cmd  in  N  per-lane load strobe
op_cyc_ctr  in  LW  value loaded on pivot_cmd
phase_id  in  $clog2(L/N+1)  region select
pivot_cyc_packed  out  LW*N  lane gi at [gi*LW +: LW]
busy  out  1  transfer in progress
mem_data  out  MW  write word; MW = N*B
mem_q  in  MW  read word
mem_addr  out  $clog2(BEATS*(L/N+1))  word address
mem_rden  out  1  read enable
mem_wren  out  1  write enable

Behaviour:
- Reset (async, rst_n=0): all lane registers 0; state IDLE; start_out, done_out, busy, mem_rden, mem_wren, and all counters 0. Reset mid-transfer abandons the transfer with no pulses.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE, pivot=1 && done_in -> WRITE. base = phase_id*BEATS is latched on entry.
- IDLE, pivot=0 && start_in -> READ. base is latched the same way.
- WRITE: beats k = 0..BEATS-1 on consecutive cycles. mem_wren=1, mem_addr=base+k, and lane gi mem_data[gi*B +: B] = pivot_cyc[gi][k*B +: B], with bits >= LW zero-padded. After beat BEATS-1: return to IDLE; done_out pulses for 1 cycle on the next cycle.
- READ: beats k = 0..BEATS-1 with mem_rden=1 and mem_addr=base+k, then go to DRAIN. Data for beat k arrives READ_LAT cycles after its rden and is written into slice k of every lane; padding bits are dropped. When the final slice is captured: return to IDLE; start_out pulses 1 cycle on the next cycle.
- busy=1 in WRITE, READ and DRAIN.
- Pass-through, registered with 1-cycle latency: pivot=1 forwards start_in to start_out; pivot=0 forwards done_in to done_out.
- pivot_cmd[gi] loads op_cyc_ctr into lane gi only in IDLE. It is ignored while busy, and restore data has priority over it.
- Trigger while busy is ignored (no queueing).
- abort in any state: next state is IDLE. rden/wren drop the same cycle abort is sampled plus one. Reads still in flight are discarded and do not modify the lanes. No start_out/done_out is generated for the aborted transfer. Pass-through pulses coincident with abort are suppressed.
- abort and a trigger in the same cycle: abort wins; stay IDLE.
- Address arithmetic: base+k must not exceed BEATS*(L/N+1)-1. Behaviour for phase_id > L/N is undefined.

Optional Feature:
PIVOT_CYC_PARITY_EN
- Defined: MW = N*(B+1). Each lane's slice gets an even-parity bit at bit N*B+gi. A parity mismatch on any captured beat sets sticky output parity_err, which clears on the next READ entry or reset.
- Undefined: MW = N*B, no parity_err port, and no parity logic.

Test Plan:
- Save/restore, N=4, L=16 (LW=4), B=2, READ_LAT=3: load lanes {3,9,12,5}; pivot=1, done_in at phase 0 -> wren at addr 0 and 1 with data 0x..; done_out 3 cycles after done_in. Then clear lanes, pivot=0, start_in -> lanes back to {3,9,12,5}; start_out exactly 2+3+1 cycles after start_in.
- Uneven width, B=3, LW=4: 2 beats, padding bits written as 0; lane value 15 round-trips exactly.
- Phase offset: phase_id=2 with B=2 -> addresses 4 and 5; phase 0 contents stay intact.
- Abort, asserted on the second read beat: no start_out, lanes unchanged, busy=0 within 2 cycles, late mem_q ignored.
- Pass-through and ignore rules: pivot=1 start_in -> start_out 1 cycle later; pivot_cmd during WRITE -> lanes unchanged; a second done_in during WRITE is ignored.
- Async reset mid-WRITE: all outputs 0 immediately, lanes 0, no done_out.
